// File: rtl/any1_bus_arbiter.sv
// Purpose: three-master round-robin arbiter for a shared bus, with a bus watchdog.
// Latency: a grant takes one clock from IDLE; bus controls and acks then pass through combinationally.
// Backpressure: a master keeps the bus while its cyc stays high. A stalled slave is aborted after TO_CYCLES clocks.
module any1_bus_arbiter #(
    parameter int TO_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [2:0]   m_cyc_i,
    input  logic [2:0]   m_stb_i,
    input  logic [2:0]   m_we_i,
    input  logic [47:0]  m_sel_i,
    input  logic [95:0]  m_adr_i,
    input  logic [383:0] m_dat_i,
    output logic [2:0]   m_ack_o,
    output logic [2:0]   m_err_o,
    output logic [127:0] m_dat_o,
    output logic [2:0]   gnt_o,
    output logic         s_vpa_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [15:0]  s_sel_o,
    output logic [31:0]  s_adr_o,
    output logic [127:0] s_dat_o,
    input  logic         s_ack_i,
    input  logic [127:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TO_CYCLES);

    state_t       state_q, state_d;
    logic [2:0]   gnt_q, gnt_d;
    // last_q doubles as the index of the current owner while a grant is held
    logic [1:0]   last_q, last_d;
    logic [7:0]   cnt_q, cnt_d;

    logic         pick_vld;
    logic [1:0]   pick_idx;

    logic         own_cyc, own_stb, own_we;
    logic [15:0]  own_sel;
    logic [31:0]  own_adr;
    logic [127:0] own_dat;
    logic         timeout;

    // Route the owning master's request signals onto one set of wires
    always_comb begin
        own_cyc = m_cyc_i[0];
        own_stb = m_stb_i[0];
        own_we  = m_we_i[0];
        own_sel = m_sel_i[15:0];
        own_adr = m_adr_i[31:0];
        own_dat = m_dat_i[127:0];
        case (last_q)
            2'd1: begin
                own_cyc = m_cyc_i[1];
                own_stb = m_stb_i[1];
                own_we  = m_we_i[1];
                own_sel = m_sel_i[31:16];
                own_adr = m_adr_i[63:32];
                own_dat = m_dat_i[255:128];
            end
            2'd2: begin
                own_cyc = m_cyc_i[2];
                own_stb = m_stb_i[2];
                own_we  = m_we_i[2];
                own_sel = m_sel_i[47:32];
                own_adr = m_adr_i[95:64];
                own_dat = m_dat_i[383:256];
            end
            default: ;
        endcase
    end

    // Round-robin choice: search from the master after the last one served
    always_comb begin
        pick_vld = |m_cyc_i;
        pick_idx = 2'd0;
        case (last_q)
            2'd0:    pick_idx = m_cyc_i[1] ? 2'd1 : (m_cyc_i[2] ? 2'd2 : 2'd0);
            2'd1:    pick_idx = m_cyc_i[2] ? 2'd2 : (m_cyc_i[0] ? 2'd0 : 2'd1);
            default: pick_idx = m_cyc_i[0] ? 2'd0 : (m_cyc_i[1] ? 2'd1 : 2'd2);
        endcase
    end

    // The watchdog fires only if the limit is reached and the slave does not ack in that same cycle
    assign timeout = (state_q == BUSY) && own_cyc && !s_ack_i && (cnt_q == TO_LIMIT);

    // State, grant, owner and watchdog registers, with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, covering grant, tenure end, watchdog count and abort
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (pick_vld) begin
                    state_d = BUSY;
                    gnt_d   = 3'b001 << pick_idx;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    cnt_d   = 8'd0;
                end else if (s_ack_i) begin
                    cnt_d = 8'd0;
                end else if (timeout) begin
                    state_d = ABORT;
                    cnt_d   = 8'd0;
                end else if (own_stb) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Drive the shared bus and the master responses; the shared bus is quiet outside BUSY
    always_comb begin
        s_vpa_o = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 16'd0;
        s_adr_o = 32'd0;
        s_dat_o = 128'd0;
        m_ack_o = 3'b000;
        m_err_o = 3'b000;
        if (state_q == BUSY) begin
            s_vpa_o = gnt_q[1] & m_cyc_i[1];
            s_cyc_o = own_cyc;
            s_stb_o = own_stb;
            s_we_o  = own_we;
            s_sel_o = own_sel;
            s_adr_o = own_adr;
            s_dat_o = own_dat;
            m_ack_o = gnt_q & {3{s_ack_i}};
            m_err_o = gnt_q & {3{timeout}};
        end
    end

    assign gnt_o   = gnt_q;
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_any1_bus_arbiter.sv
// Self-checking bench for any1_bus_arbiter, built with a short watchdog limit of 4.
// It applies a per-cycle vector table for arbitration, timeout, ack-wins and reset,
// then runs directed sequences for the fetch, write and multi-beat cases.
module tb_any1_bus_arbiter;

    logic         clk_i;
    logic         rst_ni;
    logic [2:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [47:0]  m_sel_i;
    logic [95:0]  m_adr_i;
    logic [383:0] m_dat_i;
    logic [2:0]   m_ack_o, m_err_o;
    logic [127:0] m_dat_o;
    logic [2:0]   gnt_o;
    logic         s_vpa_o, s_cyc_o, s_stb_o, s_we_o;
    logic [15:0]  s_sel_o;
    logic [31:0]  s_adr_o;
    logic [127:0] s_dat_o;
    logic         s_ack_i;
    logic [127:0] s_dat_i;

    any1_bus_arbiter #(.TO_CYCLES(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_sel_i (m_sel_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .gnt_o   (gnt_o),
        .s_vpa_o (s_vpa_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [2:0] cyc;
        logic       ack;
        logic [2:0] gnt;
        logic       scyc;
        logic       vpa;
        logic [2:0] mack;
        logic [2:0] merr;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] cyc, input logic ack,
                                input logic [2:0] gnt, input logic scyc, input logic vpa,
                                input logic [2:0] mack, input logic [2:0] merr);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.gnt = gnt;
        v.scyc = scyc; v.vpa = vpa; v.mack = mack; v.merr = merr;
        return v;
    endfunction

    function automatic logic [31:0] tbl_adr(input logic [2:0] g);
        case (g)
            3'b010:  return 32'hA000_0001;
            3'b100:  return 32'hA000_0002;
            default: return 32'hA000_0000;
        endcase
    endfunction

    // one clock: drive at the falling edge, then let outputs settle before checking
    task automatic step(input logic [2:0] cyc, input logic ack);
        @(negedge clk_i);
        m_cyc_i = cyc;
        m_stb_i = cyc;
        s_ack_i = ack;
        #1;
    endtask

    initial begin
        //                 rst  cyc     ack   gnt     scyc  vpa   mack    merr
        vecs[0]  = mk(1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000); // held in reset
        vecs[1]  = mk(1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000); // idle, grant at edge
        vecs[2]  = mk(1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 3'b001, 3'b000); // master 0 first
        vecs[3]  = mk(1'b1, 3'b110, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000); // m0 drops
        vecs[4]  = mk(1'b1, 3'b110, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000); // dead cycle
        vecs[5]  = mk(1'b1, 3'b110, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000); // master 1
        vecs[6]  = mk(1'b1, 3'b100, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[7]  = mk(1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[8]  = mk(1'b1, 3'b101, 1'b1, 3'b100, 1'b1, 1'b0, 3'b100, 3'b000); // master 2
        vecs[9]  = mk(1'b1, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[10] = mk(1'b1, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000); // ack in idle ignored
        vecs[11] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000); // master 0 again, stall
        vecs[12] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
        vecs[13] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
        vecs[14] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
        vecs[15] = mk(1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b001); // timeout pulse
        vecs[16] = mk(1'b1, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000); // abort, ack ignored
        vecs[17] = mk(1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[18] = mk(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[19] = mk(1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[20] = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
        vecs[21] = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
        vecs[22] = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
        vecs[23] = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
        vecs[24] = mk(1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000); // ack beats timeout
        vecs[25] = mk(1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
        vecs[26] = mk(1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[27] = mk(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[28] = mk(1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[29] = mk(1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000); // reset mid-tenure
        vecs[30] = mk(1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[31] = mk(1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000); // m0 first after reset
        vecs[32] = mk(1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000);
        vecs[33] = mk(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);

        rst_ni  = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        m_we_i  = 3'b000;
        m_sel_i = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        m_adr_i = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        m_dat_i = {128'h2, 128'h1, 128'h0};
        s_ack_i = 1'b0;
        s_dat_i = 128'd0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            rst_ni  = vecs[i].rst;
            m_cyc_i = vecs[i].cyc;
            m_stb_i = vecs[i].cyc;
            s_ack_i = vecs[i].ack;
            s_dat_i = 128'h5A5A_0000 + 128'(i);
            #1;
            chk($sformatf("v%0d gnt", i),   128'(gnt_o),   128'(vecs[i].gnt));
            chk($sformatf("v%0d s_cyc", i), 128'(s_cyc_o), 128'(vecs[i].scyc));
            chk($sformatf("v%0d s_stb", i), 128'(s_stb_o), 128'(vecs[i].scyc));
            chk($sformatf("v%0d s_vpa", i), 128'(s_vpa_o), 128'(vecs[i].vpa));
            chk($sformatf("v%0d m_ack", i), 128'(m_ack_o), 128'(vecs[i].mack));
            chk($sformatf("v%0d m_err", i), 128'(m_err_o), 128'(vecs[i].merr));
            chk($sformatf("v%0d m_dat", i), m_dat_o, 128'h5A5A_0000 + 128'(i));
            if (vecs[i].scyc)
                chk($sformatf("v%0d s_adr", i), 128'(s_adr_o), 128'(tbl_adr(vecs[i].gnt)));
        end

        // Master 1 instruction fetch, slave answers on the fourth bus cycle
        rst_ni = 1'b1;
        m_adr_i[63:32] = 32'hFFFC_0040;
        s_dat_i = 128'd0;
        step(3'b010, 1'b0);
        chk("fetch idle gnt", 128'(gnt_o), 128'(3'b000));
        step(3'b010, 1'b0);
        chk("fetch vpa", 128'(s_vpa_o), 128'(1'b1));
        chk("fetch adr", 128'(s_adr_o), 128'(32'hFFFC_0040));
        chk("fetch we", 128'(s_we_o), 128'(1'b0));
        chk("fetch wait ack", 128'(m_ack_o), 128'(3'b000));
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        chk("fetch wait ack3", 128'(m_ack_o), 128'(3'b000));
        s_dat_i = {112'h0, 16'hABCD};
        step(3'b010, 1'b1);
        chk("fetch ack", 128'(m_ack_o), 128'(3'b010));
        chk("fetch rdat", m_dat_o, {112'h0, 16'hABCD});
        chk("fetch no err", 128'(m_err_o), 128'(3'b000));
        step(3'b000, 1'b0);
        chk("fetch ack drop", 128'(m_ack_o), 128'(3'b000));

        // Master 0 write with partial byte select
        m_we_i = 3'b001;
        m_sel_i[15:0] = 16'h00FF;
        m_adr_i[31:0] = 32'h0000_0008;
        m_dat_i[127:0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        step(3'b001, 1'b0);
        chk("wr idle cyc", 128'(s_cyc_o), 128'(1'b0));
        step(3'b001, 1'b0);
        chk("wr gnt", 128'(gnt_o), 128'(3'b001));
        chk("wr we", 128'(s_we_o), 128'(1'b1));
        chk("wr sel", 128'(s_sel_o), 128'(16'h00FF));
        chk("wr adr", 128'(s_adr_o), 128'(32'h0000_0008));
        chk("wr dat", s_dat_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("wr no ack", 128'(m_ack_o), 128'(3'b000));
        step(3'b001, 1'b1);
        chk("wr ack", 128'(m_ack_o), 128'(3'b001));
        step(3'b000, 1'b0);
        chk("wr ack drop", 128'(m_ack_o), 128'(3'b000));
        m_we_i = 3'b000;

        // Master 2 multi-beat tenure while master 0 waits
        step(3'b100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(3'b101, 1'b1);
            chk($sformatf("burst%0d gnt", k), 128'(gnt_o), 128'(3'b100));
            chk($sformatf("burst%0d ack", k), 128'(m_ack_o), 128'(3'b100));
        end
        step(3'b001, 1'b0);
        chk("burst end gnt", 128'(gnt_o), 128'(3'b100));
        chk("burst end cyc", 128'(s_cyc_o), 128'(1'b0));
        step(3'b001, 1'b0);
        chk("burst dead gnt", 128'(gnt_o), 128'(3'b000));
        step(3'b001, 1'b0);
        chk("burst m0 gnt", 128'(gnt_o), 128'(3'b001));
        chk("burst m0 cyc", 128'(s_cyc_o), 128'(1'b1));
        step(3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/any1_bus_arbiter.md
ANY1_BUS_ARBITER -- requirements
Module: any1_bus_arbiter

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 255, meaning bus watchdog limit in clocks (8-bit counter, legal 1..255).
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port m_cyc_i  in  3  per-master bus cycle request (master 0 = data, 1 = instruction fetch, 2 = page walker).
REQ-005 SHALL have port m_stb_i / m_we_i  in  3 each  per-master strobe / write enable.
REQ-006 SHALL have port m_sel_i  in  48  byte selects, master k at bits [16k+15:16k].
REQ-007 SHALL have port m_adr_i  in  96  addresses, master k at bits [32k+31:32k].
REQ-008 SHALL have port m_dat_i  in  384  write data, master k at bits [128k+127:128k].
REQ-009 SHALL have port m_ack_o / m_err_o  out  3 each  per-master acknowledge / watchdog error.
REQ-010 SHALL have port m_dat_o  out  128  read data broadcast to all masters.
REQ-011 SHALL have port gnt_o  out  3  one-hot current grant.
REQ-012 SHALL have port s_vpa_o, s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-bus controls.
REQ-013 SHALL have port s_sel_o 16, s_adr_o 32, s_dat_o 128  out  shared-bus select/address/write data.
REQ-014 SHALL have port s_ack_i  in  1  and  s_dat_i  in  128  shared-bus acknowledge / read data.

Function
REQ-015 SHALL implement states IDLE, BUSY, ABORT.
REQ-016 IDLE: if any m_cyc_i high, SHALL grant round-robin starting at (last+1) mod 3, load gnt_o, set last=granted, enter BUSY next clock.
REQ-017 Grant latency SHALL be exactly one clock: m_cyc_i seen in IDLE at edge N -> s_cyc_o high in cycle after edge N.
REQ-018 BUSY: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o SHALL combinationally follow the granted master's inputs.
REQ-019 BUSY: m_ack_o[g] SHALL equal s_ack_i; non-granted m_ack_o bits SHALL be 0; m_dat_o SHALL equal s_dat_i at all times.
REQ-020 s_vpa_o SHALL be high only in BUSY with master 1 granted and m_cyc_i[1] high.
REQ-021 BUSY: when m_cyc_i[g] low at an edge, SHALL enter IDLE and clear gnt_o; at least one dead cycle between tenures.
REQ-022 Multi-beat tenure: master keeping m_cyc_i high SHALL retain the grant across any number of acks (no preemption).
REQ-023 Watchdog counter SHALL clear on grant and on every s_ack_i, and increment each BUSY clock with s_stb_o high and s_ack_i low.
REQ-024 When counter reaches TO_CYCLES, SHALL pulse m_err_o[g] for exactly one clock, enter ABORT, force s_cyc_o/s_stb_o low.
REQ-025 ABORT: SHALL hold grant with all s_* controls low, enter IDLE when m_cyc_i[g] low; s_ack_i ignored.
REQ-026 s_ack_i in IDLE or ABORT SHALL be ignored (no m_ack_o).
REQ-027 Ack and timeout on same edge: ack SHALL win, counter clears, no error.
REQ-028 Outside BUSY, all s_* outputs SHALL be 0.

Reset
REQ-029 rst_ni low at an edge SHALL force IDLE, gnt_o=0, last=2 (master 0 served first), counter=0, m_ack_o=m_err_o=0, all s_* controls 0.
REQ-030 Reset mid-tenure SHALL drop s_cyc_o the cycle after the reset edge; no ack forwarded thereafter.

Verification
REQ-031 Reset, then all three m_cyc_i high together -> grants in order 0,1,2,0 with one idle cycle between tenures.
REQ-032 Master 1 fetch at adr FFFC0040, slave acks after 3 clocks with dat 0x..ABCD -> s_vpa_o=1, m_ack_o=3'b010 one cycle, m_dat_o=0x..ABCD.
REQ-033 Master 0 write, sel=16'h00FF, adr=0000_0008 -> s_we_o=1, s_sel_o/s_adr_o/s_dat_o match master 0; m_ack_o[0] follows s_ack_i.
REQ-034 TO_CYCLES=4, slave never acks -> m_err_o[g] one-cycle pulse 4 clocks after s_stb_o rise, s_cyc_o low next cycle, returns IDLE after m_cyc_i drops.
REQ-035 Master 2 holds m_cyc_i for 4 acks while master 0 requests -> master 0 granted only after master 2 drops m_cyc_i, one clock later.
REQ-036 rst_ni low during master 0 tenure -> s_cyc_o=0 and gnt_o=0 next cycle; first grant after release goes to master 0.
